// File: rtl/mul_seq_ctrl.sv
// Command-driven sequencer for the combinational array multiplier: loads operands,
// waits a settle time, captures the product. Optional accumulate mode: define MUL_SEQ_ACC_EN.
module mul_seq_ctrl #(
    parameter int WIDTH      = 8,
    parameter int SETTLE_CYC = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 ena,
    input  logic                 cmd_valid,
    input  logic [1:0]           cmd,
    input  logic [WIDTH-1:0]     cmd_data,
    output logic                 cmd_ready,
    output logic [WIDTH-1:0]     mul_a,
    output logic [WIDTH-1:0]     mul_b,
    input  logic [2*WIDTH-1:0]   mul_p,
    output logic                 res_valid,
    output logic [2*WIDTH-1:0]   res_data,
    input  logic                 res_ready,
    output logic                 busy,
    output logic                 err,
    output logic                 acc_ovf
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [1:0] CMD_LOAD_A = 2'b00;
    localparam logic [1:0] CMD_LOAD_B = 2'b01;
    localparam logic [1:0] CMD_START  = 2'b10;
    localparam logic [1:0] CMD_CLEAR  = 2'b11;

    // Counter loads SETTLE_CYC-1 so capture lands exactly SETTLE_CYC edges after START.
    localparam logic [3:0] CNT_INIT = 4'(SETTLE_CYC - 1);

    state_t               state_q, state_d;
    logic [3:0]           cnt_q, cnt_d;
    logic [WIDTH-1:0]     a_q, a_d;
    logic [WIDTH-1:0]     b_q, b_d;
    logic                 a_ld_q, a_ld_d;
    logic                 b_ld_q, b_ld_d;
    logic                 err_q, err_d;
    logic                 res_valid_q, res_valid_d;
    logic [2*WIDTH-1:0]   res_data_q, res_data_d;

`ifdef MUL_SEQ_ACC_EN
    logic                 acc_ovf_q, acc_ovf_d;

    // Returns {carry, sum}; the sum wraps modulo 2^(2*WIDTH).
    function automatic logic [2*WIDTH:0] acc_add(input logic [2*WIDTH-1:0] acc,
                                                  input logic [2*WIDTH-1:0] prod);
        return {1'b0, acc} + {1'b0, prod};
    endfunction

    logic [2*WIDTH:0]     acc_sum;
    assign acc_sum = acc_add(res_data_q, mul_p);
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            a_ld_q      <= 1'b0;
            b_ld_q      <= 1'b0;
            err_q       <= 1'b0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
`ifdef MUL_SEQ_ACC_EN
            acc_ovf_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            a_q         <= a_d;
            b_q         <= b_d;
            a_ld_q      <= a_ld_d;
            b_ld_q      <= b_ld_d;
            err_q       <= err_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
`ifdef MUL_SEQ_ACC_EN
            acc_ovf_q   <= acc_ovf_d;
`endif
        end
    end

    // Everything holds by default, which also covers ena=0.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        a_d         = a_q;
        b_d         = b_q;
        a_ld_d      = a_ld_q;
        b_ld_d      = b_ld_q;
        err_d       = err_q;
        res_valid_d = res_valid_q;
        res_data_d  = res_data_q;
`ifdef MUL_SEQ_ACC_EN
        acc_ovf_d   = acc_ovf_q;
`endif
        if (ena) begin
            case (state_q)
                S_IDLE: begin
                    if (cmd_valid) begin
                        case (cmd)
                            CMD_LOAD_A: begin
                                a_d    = cmd_data;
                                a_ld_d = 1'b1;
                            end
                            CMD_LOAD_B: begin
                                b_d    = cmd_data;
                                b_ld_d = 1'b1;
                            end
                            CMD_START: begin
                                if (a_ld_q && b_ld_q) begin
                                    state_d = S_WAIT;
                                    cnt_d   = CNT_INIT;
                                end else begin
                                    err_d = 1'b1;
                                end
                            end
                            CMD_CLEAR: begin
                                a_d        = '0;
                                b_d        = '0;
                                a_ld_d     = 1'b0;
                                b_ld_d     = 1'b0;
                                err_d      = 1'b0;
                                res_data_d = '0;
`ifdef MUL_SEQ_ACC_EN
                                acc_ovf_d  = 1'b0;
`endif
                            end
                            default: ;
                        endcase
                    end
                end
                S_WAIT: begin
                    if (cnt_q == 4'd0) begin
`ifdef MUL_SEQ_ACC_EN
                        res_data_d = acc_sum[2*WIDTH-1:0];
                        if (acc_sum[2*WIDTH]) acc_ovf_d = 1'b1;
`else
                        res_data_d = mul_p;
`endif
                        res_valid_d = 1'b1;
                        state_d     = S_DONE;
                    end else begin
                        cnt_d = cnt_q - 4'd1;
                    end
                end
                S_DONE: begin
                    if (res_ready) begin
                        res_valid_d = 1'b0;
                        state_d     = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        cmd_ready = ena && (state_q == S_IDLE);
        busy      = (state_q != S_IDLE);
        mul_a     = a_q;
        mul_b     = b_q;
        res_valid = res_valid_q;
        res_data  = res_data_q;
        err       = err_q;
`ifdef MUL_SEQ_ACC_EN
        acc_ovf   = acc_ovf_q;
`else
        acc_ovf   = 1'b0;
`endif
    end

endmodule
